// File: rtl/irrigacao_multizona.sv
// irrigacao_multizona: multi-zone irrigation controller with round-robin zone scan; `AGRO_EN enables agrochemical injection
module irrigacao_multizona #(
    parameter int ZONES      = 4,
    parameter int TIMER_W    = 6,
    parameter int DRIP_TIME  = 30,
    parameter int SPRAY_TIME = 15,
    parameter int CLEAN_TIME = 5,
    parameter int AGRO_TIME  = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick,
    input  logic               H,
    input  logic               M,
    input  logic               L,
    input  logic               Ua,
    input  logic               T,
    input  logic [ZONES-1:0]   Us,
    input  logic               agro,
    output logic               Ve,
    output logic [ZONES-1:0]   zone_valve,
    output logic               spray,
    output logic               clean,
    output logic               agroOut,
    output logic               Erro,
    output logic               Alarme,
    output logic [2:0]         state,
    output logic [TIMER_W-1:0] time_left
);
    localparam int PW = $clog2(ZONES);

    typedef enum logic [2:0] {
        FILL  = 3'b000,
        IDLE  = 3'b001,
        DRIP  = 3'b010,
        SPRAY = 3'b011,
        CLEAN = 3'b100,
        ERROR = 3'b101,
        AGRO  = 3'b110
    } state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     ptr_q, ptr_d, ptr_inc;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic              alarme_q, fault, expired, busy, dry_spray;

    assign fault     = (H & ~M) | (H & ~L) | (M & ~L);
    assign expired   = tick && timer_q == TIMER_W'(1);
    assign ptr_inc   = (ptr_q == PW'(ZONES - 1)) ? '0 : ptr_q + PW'(1);
    assign dry_spray = !Ua && !T;
    assign busy      = state_q == DRIP || state_q == SPRAY || state_q == AGRO;

    // Next-state, zone pointer and phase timer; fault overrides everything
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        timer_d = timer_q;
        case (state_q)
            FILL: if (H) state_d = IDLE;
            IDLE: begin
                if (!L) state_d = FILL;
                else if (!Us[ptr_q]) begin
                    state_d = dry_spray ? SPRAY : DRIP;
                    timer_d = dry_spray ? TIMER_W'(SPRAY_TIME) : TIMER_W'(DRIP_TIME);
                end else ptr_d = ptr_inc;
            end
            DRIP, SPRAY, AGRO: begin
                if (!L) begin
                    state_d = FILL;
                    timer_d = '0;
                end else if (expired) begin
`ifdef AGRO_EN
                    state_d = (state_q != AGRO && agro) ? AGRO : CLEAN;
                    timer_d = (state_q != AGRO && agro) ? TIMER_W'(AGRO_TIME) : TIMER_W'(CLEAN_TIME);
`else
                    state_d = CLEAN;
                    timer_d = TIMER_W'(CLEAN_TIME);
`endif
                end else if (tick) timer_d = timer_q - TIMER_W'(1);
            end
            CLEAN: begin
                if (expired) begin
                    state_d = IDLE;
                    ptr_d   = ptr_inc;
                    timer_d = '0;
                end else if (tick) timer_d = timer_q - TIMER_W'(1);
            end
            default: state_d = ERROR;
        endcase
        if (fault) begin
            state_d = ERROR;
            timer_d = '0;
        end
    end

    // State registers with synchronous active-low reset; buzzer toggles per tick in ERROR
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= FILL;
            ptr_q    <= '0;
            timer_q  <= '0;
            alarme_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            timer_q  <= timer_d;
            if (state_q == ERROR && tick) alarme_q <= ~alarme_q;
        end
    end

    assign state      = state_q;
    assign Ve         = state_q == FILL;
    assign zone_valve = busy ? {{(ZONES-1){1'b0}}, 1'b1} << ptr_q : '0;
    assign spray      = state_q == SPRAY;
    assign clean      = state_q == CLEAN;
    assign Erro       = state_q == ERROR;
    assign Alarme     = alarme_q;
    assign time_left  = (busy || state_q == CLEAN) ? timer_q : '0;
`ifdef AGRO_EN
    assign agroOut    = state_q == AGRO;
`else
    logic unused_agro;
    assign unused_agro = agro & (AGRO_TIME != 0);
    assign agroOut     = 1'b0;
`endif
endmodule

// File: tb/tb_irrigacao_multizona.sv
// tb_irrigacao_multizona: scoreboard bench with directed vectors for irrigacao_multizona
module tb_irrigacao_multizona;
    localparam logic [2:0] S_FILL = 3'b000, S_IDLE = 3'b001, S_DRIP = 3'b010, S_SPRAY = 3'b011,
                           S_CLEAN = 3'b100, S_ERROR = 3'b101, S_AGRO = 3'b110;

    logic       clk = 0, reset = 0, tick = 0, H = 0, M = 0, L = 0, Ua = 0, T = 0, agro = 0;
    logic [3:0] Us = 4'b1111;
    logic       Ve, spray, clean, agroOut, Erro, Alarme;
    logic [3:0] zone_valve;
    logic [2:0] state;
    logic [5:0] time_left;

    typedef struct packed {
        logic [2:0] st;
        logic [3:0] zv;
        logic       sp, cl, ag, ve, er, al;
        logic [5:0] tl;
    } exp_t;

    exp_t  eq[$];
    string nq[$];
    int    total = 0, passed = 0;

    irrigacao_multizona dut (
        .clk(clk), .reset(reset), .tick(tick), .H(H), .M(M), .L(L), .Ua(Ua), .T(T),
        .Us(Us), .agro(agro), .Ve(Ve), .zone_valve(zone_valve), .spray(spray),
        .clean(clean), .agroOut(agroOut), .Erro(Erro), .Alarme(Alarme),
        .state(state), .time_left(time_left)
    );

    always #5 clk = ~clk;

    // Monitor: compare DUT outputs against the oldest pending expectation on each falling edge
    initial begin
        exp_t  e, a;
        string n;
        forever begin
            @(negedge clk);
            if (eq.size() > 0) begin
                e = eq.pop_front();
                n = nq.pop_front();
                a = {state, zone_valve, spray, clean, agroOut, Ve, Erro, Alarme, time_left};
                total++;
                if (a === e) passed++;
                else $display("FAIL %s: got st=%b zv=%b sp/cl/ag/ve/er/al=%b tl=%0d, expected st=%b zv=%b sp/cl/ag/ve/er/al=%b tl=%0d",
                              n, a.st, a.zv, {a.sp, a.cl, a.ag, a.ve, a.er, a.al}, a.tl,
                              e.st, e.zv, {e.sp, e.cl, e.ag, e.ve, e.er, e.al}, e.tl);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic tk(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1;
            cyc();
            tick = 0;
        end
    endtask

    task automatic ex(input string n, input logic [2:0] st, input logic [3:0] zv,
                      input logic sp, input logic cl, input logic ag, input logic ve,
                      input logic er, input logic al, input logic [5:0] tl);
        eq.push_back({st, zv, sp, cl, ag, ve, er, al, tl});
        nq.push_back(n);
    endtask

    initial begin
        cyc();
        ex("reset_state", S_FILL, 4'b0000, 0, 0, 0, 1, 0, 0, 0);
        cyc();
        reset = 1;
        cyc();
        ex("fill_wait_high", S_FILL, 4'b0000, 0, 0, 0, 1, 0, 0, 0);
        H = 1; M = 1; L = 1; Us = 4'b1011; Ua = 1; T = 0;
        cyc();
        ex("fill_to_idle", S_IDLE, 4'b0000, 0, 0, 0, 0, 0, 0, 0);
        cyc();
        cyc();
        tick = 1;
        cyc();
        tick = 0;
        ex("drip_zone2_load", S_DRIP, 4'b0100, 0, 0, 0, 0, 0, 0, 30);
        Us = 4'b0111;
        tk(1);
        ex("drip_first_tick", S_DRIP, 4'b0100, 0, 0, 0, 0, 0, 0, 29);
        tk(27);
        cyc();
        ex("drip_no_tick_hold", S_DRIP, 4'b0100, 0, 0, 0, 0, 0, 0, 2);
        tk(1);
        ex("drip_last_tick", S_DRIP, 4'b0100, 0, 0, 0, 0, 0, 0, 1);
        tk(1);
        ex("drip_to_clean", S_CLEAN, 4'b0000, 0, 1, 0, 0, 0, 0, 5);
        tk(4);
        ex("clean_last_tick", S_CLEAN, 4'b0000, 0, 1, 0, 0, 0, 0, 1);
        tk(1);
        ex("clean_to_idle", S_IDLE, 4'b0000, 0, 0, 0, 0, 0, 0, 0);
        cyc();
        ex("ptr3_drip", S_DRIP, 4'b1000, 0, 0, 0, 0, 0, 0, 30);
        tk(18);
        ex("drip_at_12", S_DRIP, 4'b1000, 0, 0, 0, 0, 0, 0, 12);
        H = 0; M = 0; L = 0; tick = 1;
        cyc();
        tick = 0;
        ex("tank_empty_fill", S_FILL, 4'b0000, 0, 0, 0, 1, 0, 0, 0);
        H = 1; M = 1; L = 1;
        cyc();
        ex("refill_idle", S_IDLE, 4'b0000, 0, 0, 0, 0, 0, 0, 0);
        cyc();
        ex("restart_full_timer", S_DRIP, 4'b1000, 0, 0, 0, 0, 0, 0, 30);
        Us = 4'b1110; Ua = 0; T = 0;
        tk(30);
        ex("drip3_to_clean", S_CLEAN, 4'b0000, 0, 1, 0, 0, 0, 0, 5);
        tk(5);
        ex("clean_wrap_idle", S_IDLE, 4'b0000, 0, 0, 0, 0, 0, 0, 0);
        cyc();
        ex("spray_zone0", S_SPRAY, 4'b0001, 1, 0, 0, 0, 0, 0, 15);
        tk(3);
        ex("spray_at_12", S_SPRAY, 4'b0001, 1, 0, 0, 0, 0, 0, 12);
        H = 1; M = 0; L = 1;
        cyc();
        ex("fault_error", S_ERROR, 4'b0000, 0, 0, 0, 0, 1, 0, 0);
        tk(1);
        ex("alarm_toggle_on", S_ERROR, 4'b0000, 0, 0, 0, 0, 1, 1, 0);
        tk(1);
        ex("alarm_toggle_off", S_ERROR, 4'b0000, 0, 0, 0, 0, 1, 0, 0);
        H = 1; M = 1; L = 1;
        cyc();
        ex("error_sticky", S_ERROR, 4'b0000, 0, 0, 0, 0, 1, 0, 0);
        reset = 0;
        cyc();
        ex("reset_from_error", S_FILL, 4'b0000, 0, 0, 0, 1, 0, 0, 0);
        reset = 1; Ua = 1; agro = 1;
        cyc();
        ex("post_reset_idle", S_IDLE, 4'b0000, 0, 0, 0, 0, 0, 0, 0);
        cyc();
        ex("drip_zone0", S_DRIP, 4'b0001, 0, 0, 0, 0, 0, 0, 30);
        tk(30);
`ifdef AGRO_EN
        ex("drip_to_agro", S_AGRO, 4'b0001, 0, 0, 1, 0, 0, 0, 10);
        tk(10);
        ex("agro_to_clean", S_CLEAN, 4'b0000, 0, 1, 0, 0, 0, 0, 5);
`else
        ex("agro_ignored_clean", S_CLEAN, 4'b0000, 0, 1, 0, 0, 0, 0, 5);
`endif
        tk(2);
        ex("clean_mid", S_CLEAN, 4'b0000, 0, 1, 0, 0, 0, 0, 3);
        reset = 0;
        cyc();
        ex("reset_mid_phase", S_FILL, 4'b0000, 0, 0, 0, 1, 0, 0, 0);
        reset = 1;
        cyc();
        @(negedge clk);
        #1;
        if (eq.size() != 0) begin
            total++;
            $display("FAIL drain: %0d expectations unchecked, expected 0", eq.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
